sdram_responder: RTL and testbench
==================================

# sdram_responder

Synthesisable SDR SDRAM device-side responder: the memory end of the 32-bit SDRAM command bus our MPSoC top levels drive off-chip. It decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, and accepts write bursts. It returns read bursts after the programmed CAS latency from an internal array. It replaces the DE2-115 SDRAM chip in simulation and in loopback FPGA builds, and flags controller protocol violations.

## Interface
- `BA_W`, 2, bank address width (4 banks)
- `ADDR_W`, 13, row/mode address width
- `COL_W`, 10, column bits taken from `sdram_addr`
- `ROW_USED`, 4, low row bits backed by storage; upper row bits alias
- `DQ_W`, 32, data width; `DQM_W` = `DQ_W`/8
- `T_RCD`, 2, minimum cycles from ACT to READ/WRITE on the same bank
- `clk`  in  1  system clock; all edges are rising
- `reset`  in  1  synchronous, active-high
- `sdram_cke`  in  1  clock enable; low = no command decoded, bursts frozen
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  in  1 each  command
- `sdram_ba`  in  BA_W  bank
- `sdram_addr`  in  ADDR_W  row / column / mode value
- `sdram_dqm`  in  DQM_W  write byte mask, 1 = byte not written
- `sdram_dq_in`  in  DQ_W  write data
- `sdram_dq_out`  out  DQ_W  read data
- `sdram_dq_oe`  out  1  read data valid / drive enable
- `err`  out  1  sticky protocol error
- `err_code`  out  3  code of the first error
- `ref_count`  out  16  AUTO REFRESH count, saturating at 0xFFFF

## Operation
- Command {cs_n,ras_n,cas_n,we_n}, decoded only when cke=1:
  - 1xxx or 0111 = NOP
  - 0011 = ACT
  - 0101 = READ
  - 0100 = WRITE
  - 0010 = PRE; addr[10]=1 precharges all banks
  - 0001 = REF
  - 0000 = LMR
  - 0110 = BST
- LMR sets CL = addr[6:4] and BL = addr[2:0]:
  - CL accepts 2 or 3; any other value keeps the old CL and sets error 5.
  - BL codes 0,1,2,3 select burst length 1,2,4,8; any other code gives BL=1.
- ACT: bank becomes active and stores the row. PRE: bank becomes idle.
- Storage word index = {ba, row[ROW_USED-1:0], col}.
  - Burst column sequence: sequential from the start column, wrapping inside the BL-aligned block. Example: BL=4, start col 6 gives 6,7,4,5.
- WRITE:
  - The first word is captured at the command edge from `sdram_dq_in`.
  - Following words are captured on the following BL-1 edges.
  - `sdram_dqm` is applied per byte on each captured word.
- READ: read data goes into a CL-stage pipeline. `sdram_dqm` is ignored on reads.
- Any READ, WRITE, BST, or PRE (all banks, or the burst's bank) terminates the current burst. Read words already inside the pipeline still emerge.
- Memory contents are not cleared by reset.
- Error codes; only the first error is latched, and `err` holds until reset:
  - 1 = ACT to an active bank
  - 2 = READ/WRITE to an idle bank
  - 3 = READ/WRITE earlier than T_RCD cycles after ACT
  - 4 = REF while any bank is active
  - 5 = illegal CL in LMR
- Reset state: all banks idle, CL=3, BL=1, bursts and pipeline flushed.
- Output reset values: `sdram_dq_out`=0, `sdram_dq_oe`=0, `err`=0, `err_code`=0, `ref_count`=0.

## Timing
- READ sampled at edge n:
  - `sdram_dq_out`/`sdram_dq_oe` update at edge n+CL-1 and hold one cycle, so the controller samples at edge n+CL.
  - Burst word i appears one cycle after word i-1.
- WRITE word latency is 0: data is sampled together with the command.
- A read burst followed back-to-back by READ at edge n+BL gives a gapless `sdram_dq_oe`.
- cke=0 at an edge: no decode, burst counter and CL pipeline hold, outputs hold.
- The T_RCD check passes when command edge - ACT edge >= T_RCD.

## Configuration
- `SDRAM_RESPONDER_CHECK_EN` defined: all error detection is active, including the T_RCD counters.
- Not defined:
  - `err` and `err_code` are tied to 0.
  - Illegal commands execute anyway: ACT to an active bank overwrites the row; READ/WRITE to an idle bank uses the last stored row.
  - LMR with an illegal CL keeps the old CL.

## Structure
- `sdram_responder_pkg` holds:
  - command encodings (4-bit constants)
  - error-code constants
  - the BL decode function
  - the burst-wrap column function
- Sub-module `sdram_responder_bank`, instantiated once per bank, holds:
  - active flag
  - open row
  - T_RCD down-counter
  - ACT/PRE/access-legality outputs
- The top level holds command decode, the mode register, the burst generator, the CL pipeline, and the storage array.

## Test plan
- Basic read: reset, LMR 0x030 (CL3, BL1), ACT bank1 row 5, WRITE col 3 data 0xDEADBEEF, READ col 3 → `sdram_dq_oe` high exactly 2 cycles after the READ edge with 0xDEADBEEF; `err`=0.
- Burst wrap: LMR 0x022 (CL2, BL4), write burst col 6 with data 0xA0..0xA3, then read col 6 → read words 0xA0,0xA1,0xA2,0xA3 returned from cols 6,7,4,5, one per cycle starting 1 cycle after READ.
- Byte mask: write 0xFFFFFFFF, then write 0x12345678 with dqm=4'b0101 → readback 0x12FF56FF.
- Interrupt: BL=8 read interrupted by PRE at the 3rd word → exactly the 3 issued words plus in-flight pipeline words, then `sdram_dq_oe` low.
- Errors (macro on): READ to idle bank → `err`=1, `err_code`=2; a later ACT-to-active still leaves code 2.
- T_RCD / refresh (macro on): READ 1 cycle after ACT with T_RCD=2 → code 3. Separately, after reset, 3 REFs with all banks idle → `ref_count`=3, `err`=0.

Source files
------------

// File: rtl/sdram_responder_pkg.sv
// sdram_responder_pkg: command encodings, error codes and burst helpers for sdram_responder
package sdram_responder_pkg;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;
  localparam logic [3:0] CMD_BST   = 4'b0110;
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ACT   = 3'd1;
  localparam logic [2:0] ERR_IDLE  = 3'd2;
  localparam logic [2:0] ERR_RCD   = 3'd3;
  localparam logic [2:0] ERR_REF   = 3'd4;
  localparam logic [2:0] ERR_CL    = 3'd5;
  function automatic logic [3:0] bl_decode(input logic [2:0] code);
    return code > 3'd3 ? 4'd1 : 4'd1 << code;
  endfunction
  function automatic logic [15:0] burst_col(input logic [15:0] start, input logic [3:0] idx, input logic [3:0] bl);
    logic [15:0] m;
    m = {12'd0, bl - 4'd1};
    return (start & ~m) | ((start + {12'd0, idx}) & m);
  endfunction
endpackage

// File: rtl/sdram_responder_bank.sv
// sdram_responder_bank: per-bank open row, T_RCD timer (SDRAM_RESPONDER_CHECK_EN) and access legality
module sdram_responder_bank #(
  parameter int ROW_W = 4,
  parameter int T_RCD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             act,
  input  logic             pre,
  input  logic             acc,
  input  logic [ROW_W-1:0] row_in,
  output logic             active,
  output logic [ROW_W-1:0] row,
  output logic             act_err,
  output logic             idle_err,
  output logic             rcd_err
);
  logic active_q, active_d;
  logic [ROW_W-1:0] row_q, row_d;
  always_comb begin
    active_d = act ? 1'b1 : pre ? 1'b0 : active_q;
    row_d = act ? row_in : row_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      row_q <= '0;
    end else begin
      active_q <= active_d;
      row_q <= row_d;
    end
  end
  assign active = active_q;
  assign row = row_q;
  assign act_err = act && active_q;
  assign idle_err = acc && !active_q;
`ifdef SDRAM_RESPONDER_CHECK_EN
  localparam int CW = $clog2(T_RCD + 1);
  logic [CW-1:0] rcd_q, rcd_d;
  always_comb rcd_d = act ? CW'(T_RCD - 1) : rcd_q != '0 ? rcd_q - CW'(1) : rcd_q;
  always_ff @(posedge clk) begin
    if (reset) rcd_q <= '0;
    else rcd_q <= rcd_d;
  end
  assign rcd_err = acc && active_q && rcd_q != '0;
`else
  logic unused_rcd;
  assign unused_rcd = T_RCD[0];
  assign rcd_err = 1'b0;
`endif
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device-side responder; define SDRAM_RESPONDER_CHECK_EN to enable protocol error checks
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int BA_W = 2,
  parameter int ADDR_W = 13,
  parameter int COL_W = 10,
  parameter int ROW_USED = 4,
  parameter int DQ_W = 32,
  parameter int DQM_W = DQ_W / 8,
  parameter int T_RCD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdram_cke,
  input  logic              sdram_cs_n,
  input  logic              sdram_ras_n,
  input  logic              sdram_cas_n,
  input  logic              sdram_we_n,
  input  logic [BA_W-1:0]   sdram_ba,
  input  logic [ADDR_W-1:0] sdram_addr,
  input  logic [DQM_W-1:0]  sdram_dqm,
  input  logic [DQ_W-1:0]   sdram_dq_in,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [15:0]       ref_count
);
  localparam int NB = 1 << BA_W;
  localparam int IDX_W = BA_W + ROW_USED + COL_W;
  logic [3:0] cmd;
  logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;
  logic new_acc, kill, cont, iss_v, iss_rd, cl_ok;
  logic [NB-1:0] b_active, b_act, b_pre, b_acc, act_e, idle_e, rcd_e;
  logic [ROW_USED-1:0] b_row [NB];
  logic [BA_W-1:0] iss_ba, bst_ba_q, bst_ba_d;
  logic [ROW_USED-1:0] iss_row, bst_row_q, bst_row_d;
  logic [COL_W-1:0] col_start, iss_col, bst_col_q, bst_col_d;
  logic [3:0] iss_i, bst_i_q, bst_i_d, bst_cnt_q, bst_cnt_d, bl_q, bl_d;
  logic bst_rd_q, bst_rd_d, cl3_q, cl3_d;
  logic [IDX_W-1:0] iss_idx;
  logic [DQ_W-1:0] mem [1 << IDX_W];
  logic [DQ_W-1:0] rd_word, wr_word, p0_d_q, p0_d_d, p1_d_q, p1_d_d, dq_q, dq_d;
  logic p0_v_q, p0_v_d, p1_v_q, p1_v_d, oe_q, oe_d;
  logic [15:0] ref_q, ref_d;
  logic unused;
  assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign is_act = sdram_cke && cmd == CMD_ACT;
  assign is_rd = sdram_cke && cmd == CMD_READ;
  assign is_wr = sdram_cke && cmd == CMD_WRITE;
  assign is_pre = sdram_cke && cmd == CMD_PRE;
  assign is_ref = sdram_cke && cmd == CMD_REF;
  assign is_lmr = sdram_cke && cmd == CMD_LMR;
  assign is_bst = sdram_cke && cmd == CMD_BST;
  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign b_act[b] = is_act && sdram_ba == BA_W'(b);
    assign b_pre[b] = is_pre && (sdram_addr[10] || sdram_ba == BA_W'(b));
    assign b_acc[b] = (is_rd || is_wr) && sdram_ba == BA_W'(b);
    sdram_responder_bank #(.ROW_W(ROW_USED), .T_RCD(T_RCD)) u_bank (
      .clk(clk),
      .reset(reset),
      .act(b_act[b]),
      .pre(b_pre[b]),
      .acc(b_acc[b]),
      .row_in(sdram_addr[ROW_USED-1:0]),
      .active(b_active[b]),
      .row(b_row[b]),
      .act_err(act_e[b]),
      .idle_err(idle_e[b]),
      .rcd_err(rcd_e[b])
    );
  end
  always_comb begin
    new_acc = is_rd || is_wr;
    kill = is_bst || (is_pre && (sdram_addr[10] || sdram_ba == bst_ba_q));
    cont = sdram_cke && bst_cnt_q != '0 && !new_acc && !kill;
    iss_v = new_acc || cont;
    iss_rd = new_acc ? is_rd : bst_rd_q;
    iss_ba = new_acc ? sdram_ba : bst_ba_q;
    iss_row = new_acc ? b_row[sdram_ba] : bst_row_q;
    col_start = new_acc ? sdram_addr[COL_W-1:0] : bst_col_q;
    iss_i = new_acc ? 4'd0 : bst_i_q;
    iss_col = COL_W'(burst_col(16'(col_start), iss_i, bl_q));
    iss_idx = {iss_ba, iss_row, iss_col};
    rd_word = mem[iss_idx];
    wr_word = rd_word;
    for (int k = 0; k < DQM_W; k++) wr_word[8*k +: 8] = sdram_dqm[k] ? rd_word[8*k +: 8] : sdram_dq_in[8*k +: 8];
    bst_cnt_d = new_acc ? bl_q - 4'd1 : kill ? 4'd0 : cont ? bst_cnt_q - 4'd1 : bst_cnt_q;
    bst_i_d = new_acc ? 4'd1 : cont ? bst_i_q + 4'd1 : bst_i_q;
    bst_rd_d = new_acc ? is_rd : bst_rd_q;
    bst_ba_d = new_acc ? sdram_ba : bst_ba_q;
    bst_row_d = new_acc ? iss_row : bst_row_q;
    bst_col_d = new_acc ? col_start : bst_col_q;
    p0_v_d = sdram_cke ? iss_v && iss_rd : p0_v_q;
    p0_d_d = sdram_cke ? (iss_v && iss_rd ? rd_word : '0) : p0_d_q;
    p1_v_d = sdram_cke ? p0_v_q : p1_v_q;
    p1_d_d = sdram_cke ? p0_d_q : p1_d_q;
    oe_d = sdram_cke ? (cl3_q ? p1_v_q : p0_v_q) : oe_q;
    dq_d = sdram_cke ? (cl3_q ? p1_d_q : p0_d_q) : dq_q;
    cl_ok = sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3;
    cl3_d = is_lmr && cl_ok ? sdram_addr[4] : cl3_q;
    bl_d = is_lmr ? bl_decode(sdram_addr[2:0]) : bl_q;
    ref_d = is_ref && ref_q != 16'hFFFF ? ref_q + 16'd1 : ref_q;
  end
  always_ff @(posedge clk) begin
    if (iss_v && !iss_rd) mem[iss_idx] <= wr_word;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bst_cnt_q <= '0;
      bst_i_q <= '0;
      bst_rd_q <= 1'b0;
      bst_ba_q <= '0;
      bst_row_q <= '0;
      bst_col_q <= '0;
      p0_v_q <= 1'b0;
      p0_d_q <= '0;
      p1_v_q <= 1'b0;
      p1_d_q <= '0;
      oe_q <= 1'b0;
      dq_q <= '0;
      cl3_q <= 1'b1;
      bl_q <= 4'd1;
      ref_q <= '0;
    end else begin
      bst_cnt_q <= bst_cnt_d;
      bst_i_q <= bst_i_d;
      bst_rd_q <= bst_rd_d;
      bst_ba_q <= bst_ba_d;
      bst_row_q <= bst_row_d;
      bst_col_q <= bst_col_d;
      p0_v_q <= p0_v_d;
      p0_d_q <= p0_d_d;
      p1_v_q <= p1_v_d;
      p1_d_q <= p1_d_d;
      oe_q <= oe_d;
      dq_q <= dq_d;
      cl3_q <= cl3_d;
      bl_q <= bl_d;
      ref_q <= ref_d;
    end
  end
  assign sdram_dq_out = dq_q;
  assign sdram_dq_oe = oe_q;
  assign ref_count = ref_q;
`ifdef SDRAM_RESPONDER_CHECK_EN
  logic err_q, err_d;
  logic [2:0] code_q, code_d, new_code;
  always_comb begin
    new_code = |act_e ? ERR_ACT : |idle_e ? ERR_IDLE : |rcd_e ? ERR_RCD :
               is_ref && |b_active ? ERR_REF : is_lmr && !cl_ok ? ERR_CL : ERR_NONE;
    err_d = err_q || new_code != ERR_NONE;
    code_d = err_q ? code_q : new_code;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      err_q <= err_d;
      code_q <= code_d;
    end
  end
  assign err = err_q;
  assign err_code = code_q;
  assign unused = ^sdram_addr;
`else
  assign err = 1'b0;
  assign err_code = '0;
  assign unused = ^{sdram_addr, b_active, act_e, idle_e, rcd_e};
`endif
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed self-checking bench for sdram_responder
module tb_sdram_responder;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;
  logic clk = 1'b0, reset = 1'b1, cke = 1'b1;
  logic cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0] ba = '0;
  logic [12:0] addr = '0;
  logic [3:0] dqm = '0;
  logic [31:0] dq_in = '0, dq_out;
  logic oe, err;
  logic [2:0] err_code;
  logic [15:0] ref_count;
  int total = 0, bad = 0;
  sdram_responder dut (
    .clk(clk), .reset(reset), .sdram_cke(cke),
    .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_ba(ba), .sdram_addr(addr), .sdram_dqm(dqm), .sdram_dq_in(dq_in),
    .sdram_dq_out(dq_out), .sdram_dq_oe(oe), .err(err), .err_code(err_code), .ref_count(ref_count)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic [31:0] d, input logic [3:0] m);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    dq_in = d;
    dqm = m;
    @(posedge clk);
    #1;
    {cs_n, ras_n, cas_n, we_n} = NOP;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (dq_out !== 32'h0) begin bad++; $display("FAIL reset_dq: got %h want 0", dq_out); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", oe); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", err_code); end
    total++; if (ref_count !== 16'd0) begin bad++; $display("FAIL reset_ref: got %0d want 0", ref_count); end
  endtask
  task automatic test_basic_read();
    issue(LMR, 0, 13'h030, 0, 0);
    issue(ACT, 1, 13'd5, 0, 0);
    issue(NOP, 0, 0, 0, 0);
    issue(WR, 1, 13'd3, 32'hDEADBEEF, 0);
    issue(RD, 1, 13'd3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++; if (oe !== (i == 2)) begin bad++; $display("FAIL basic_oe[%0d]: got %b want %b", i, oe, i == 2); end
      if (i == 2) begin
        total++; if (dq_out !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_dq: got %h want deadbeef", dq_out); end
      end
      issue(NOP, 0, 0, 0, 0);
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err); end
  endtask
  task automatic test_burst_wrap();
    logic [31:0] exp_w [8];
    logic exp_v;
    exp_w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA2, 32'hA3, 32'hA0, 32'hA1};
    issue(LMR, 0, 13'h022, 0, 0);
    issue(WR, 1, 13'd6, 32'hA0, 0);
    issue(NOP, 0, 0, 32'hA1, 0);
    issue(NOP, 0, 0, 32'hA2, 0);
    issue(NOP, 0, 0, 32'hA3, 0);
    for (int i = 0; i < 10; i++) begin
      issue((i == 0 || i == 4) ? RD : NOP, 1, (i == 4) ? 13'd4 : 13'd6, 0, 0);
      exp_v = i >= 1 && i <= 8;
      total++; if (oe !== exp_v) begin bad++; $display("FAIL wrap_oe[%0d]: got %b want %b", i, oe, exp_v); end
      if (exp_v) begin
        total++; if (dq_out !== exp_w[i-1]) begin bad++; $display("FAIL wrap_dq[%0d]: got %h want %h", i, dq_out, exp_w[i-1]); end
      end
    end
  endtask
  task automatic test_byte_mask();
    issue(LMR, 0, 13'h020, 0, 0);
    issue(WR, 1, 13'd20, 32'hFFFFFFFF, 4'b0000);
    issue(WR, 1, 13'd20, 32'h12345678, 4'b0101);
    issue(RD, 1, 13'd20, 0, 4'b1111);
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL mask_oe0: got %b want 0", oe); end
    issue(NOP, 0, 0, 0, 0);
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL mask_oe1: got %b want 1", oe); end
    total++; if (dq_out !== 32'h12FF56FF) begin bad++; $display("FAIL mask_dq: got %h want 12ff56ff", dq_out); end
  endtask
  task automatic test_interrupt();
    logic exp_v;
    issue(LMR, 0, 13'h033, 0, 0);
    issue(WR, 1, 13'd8, 32'hB0, 0);
    for (int i = 1; i < 8; i++) issue(NOP, 0, 0, 32'hB0 + i, 0);
    for (int i = 0; i < 9; i++) begin
      issue(i == 0 ? RD : i == 3 ? PRE : NOP, 1, i == 0 ? 13'd8 : 13'd0, 0, 0);
      exp_v = i >= 2 && i <= 4;
      total++; if (oe !== exp_v) begin bad++; $display("FAIL intr_oe[%0d]: got %b want %b", i, oe, exp_v); end
      if (exp_v) begin
        total++; if (dq_out !== 32'hB0 + (i - 2)) begin bad++; $display("FAIL intr_dq[%0d]: got %h want %h", i, dq_out, 32'hB0 + (i - 2)); end
      end
    end
  endtask
  task automatic test_errors();
    logic exp_e;
    logic [2:0] exp_c;
`ifdef SDRAM_RESPONDER_CHECK_EN
    exp_e = 1'b1;
    exp_c = 3'd2;
`else
    exp_e = 1'b0;
    exp_c = 3'd0;
`endif
    issue(RD, 2, 13'd0, 0, 0);
    total++; if (err !== exp_e) begin bad++; $display("FAIL idle_err: got %b want %b", err, exp_e); end
    total++; if (err_code !== exp_c) begin bad++; $display("FAIL idle_code: got %0d want %0d", err_code, exp_c); end
    issue(ACT, 0, 13'd1, 0, 0);
    issue(ACT, 0, 13'd2, 0, 0);
    total++; if (err !== exp_e) begin bad++; $display("FAIL sticky_err: got %b want %b", err, exp_e); end
    total++; if (err_code !== exp_c) begin bad++; $display("FAIL sticky_code: got %0d want %0d", err_code, exp_c); end
  endtask
  task automatic test_rcd();
    logic [2:0] exp_c;
`ifdef SDRAM_RESPONDER_CHECK_EN
    exp_c = 3'd3;
`else
    exp_c = 3'd0;
`endif
    do_reset();
    issue(ACT, 0, 13'd1, 0, 0);
    issue(NOP, 0, 0, 0, 0);
    issue(RD, 0, 13'd0, 0, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rcd_ok_err: got %b want 0", err); end
    issue(ACT, 2, 13'd1, 0, 0);
    issue(RD, 2, 13'd0, 0, 0);
    total++; if (err_code !== exp_c) begin bad++; $display("FAIL rcd_code: got %0d want %0d", err_code, exp_c); end
  endtask
  task automatic test_refresh();
    logic [2:0] exp_c;
`ifdef SDRAM_RESPONDER_CHECK_EN
    exp_c = 3'd4;
`else
    exp_c = 3'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) issue(REF, 0, 0, 0, 0);
    total++; if (ref_count !== 16'd3) begin bad++; $display("FAIL ref_count: got %0d want 3", ref_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ref_err: got %b want 0", err); end
    issue(ACT, 0, 13'd0, 0, 0);
    issue(REF, 0, 0, 0, 0);
    total++; if (err_code !== exp_c) begin bad++; $display("FAIL ref_active_code: got %0d want %0d", err_code, exp_c); end
  endtask
  task automatic test_illegal_cl();
    logic [2:0] exp_c;
`ifdef SDRAM_RESPONDER_CHECK_EN
    exp_c = 3'd5;
`else
    exp_c = 3'd0;
`endif
    do_reset();
    issue(LMR, 0, 13'h050, 0, 0);
    total++; if (err_code !== exp_c) begin bad++; $display("FAIL cl_code: got %0d want %0d", err_code, exp_c); end
    issue(ACT, 1, 13'd7, 0, 0);
    issue(NOP, 0, 0, 0, 0);
    issue(WR, 1, 13'd1, 32'h5A5A0001, 0);
    issue(RD, 1, 13'd1, 0, 0);
    issue(NOP, 0, 0, 0, 0);
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL cl_keep_oe1: got %b want 0", oe); end
    issue(NOP, 0, 0, 0, 0);
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL cl_keep_oe2: got %b want 1", oe); end
    total++; if (dq_out !== 32'h5A5A0001) begin bad++; $display("FAIL cl_keep_dq: got %h want 5a5a0001", dq_out); end
  endtask
  task automatic test_cke();
    logic [31:0] exp_w [7];
    exp_w = '{32'hC0, 32'hC0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'h0};
    issue(LMR, 0, 13'h022, 0, 0);
    issue(WR, 1, 13'h10, 32'hC0, 0);
    issue(NOP, 0, 0, 32'hC1, 0);
    issue(NOP, 0, 0, 32'hC2, 0);
    issue(NOP, 0, 0, 32'hC3, 0);
    issue(RD, 1, 13'h10, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cke = !(i == 1 || i == 2);
      issue(i == 2 ? RD : NOP, 1, 13'h12, 0, 0);
      total++; if (oe !== (i < 6)) begin bad++; $display("FAIL cke_oe[%0d]: got %b want %b", i, oe, i < 6); end
      if (i < 6) begin
        total++; if (dq_out !== exp_w[i]) begin bad++; $display("FAIL cke_dq[%0d]: got %h want %h", i, dq_out, exp_w[i]); end
      end
    end
    cke = 1'b1;
  endtask
  initial begin
    test_reset();
    test_basic_read();
    test_burst_wrap();
    test_byte_mask();
    test_interrupt();
    test_errors();
    test_rcd();
    test_refresh();
    test_illegal_cl();
    test_cke();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
